// File: rtl/memch_readout_sequencer_pkg.sv
// Shared definitions for the memory-channel readout sequencer: state encoding and width helpers.
package memch_readout_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_FLAG     = 3'd1;
  localparam logic [STATE_W-1:0] ST_READ     = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_ADV = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd5;

  // Channel index width; a single-channel build still needs one select bit.
  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/memch_readout_sequencer_skid_buffer.sv
// Two-entry FIFO between channel-memory read data and the output stream; falling-edge clocked.
module memch_skid_buffer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full buffer is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/memch_readout_sequencer.sv
// Streams one finished channel out of channel memory per Channel_Done, handshaking with the
// memory channel controller via New_Channel_Flag / In_Output_Routine / Ch_Advance.
module memch_readout_sequencer
  import memch_readout_sequencer_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ADDR_WIDTH = 10,
  parameter  int unsigned PIXELS     = 900,
  parameter  int unsigned CHANNELS   = 3,
  localparam int unsigned CH_W       = ch_width(CHANNELS)
) (
  input  logic                  MEMCH_READOUT_Clk,
  input  logic                  MEMCH_STATEMACHINE_Reset,
  input  logic                  MEMCH_READOUT_Channel_Done,
  input  logic                  MEMCH_READOUT_Ch_Advance,
  output logic                  MEMCH_READOUT_Rd_En,
  output logic [ADDR_WIDTH-1:0] MEMCH_READOUT_Rd_Addr,
  output logic [CH_W-1:0]       MEMCH_READOUT_Rd_Sel,
  input  logic [DATA_WIDTH-1:0] MEMCH_READOUT_Rd_Data,
  output logic [DATA_WIDTH-1:0] MEMCH_READOUT_Out_Data,
  output logic                  MEMCH_READOUT_Out_Valid,
  input  logic                  MEMCH_READOUT_Out_Ready,
  output logic                  MEMCH_READOUT_Out_Last,
  output logic                  MEMCH_READOUT_New_Channel_Flag,
  output logic                  MEMCH_READOUT_In_Output_Routine,
  output logic                  MEMCH_READOUT_Frame_Done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(CHANNELS - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  in_flight_q, in_flight_d;
  logic                  last_in_flight_q, last_in_flight_d;
  logic                  rd_en, new_flag, in_routine, frame_done;
  logic                  out_valid, pop;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH:0]   buf_head;
  logic [2:0]            occupancy;

  // State and datapath registers, updated on the falling edge.
  always_ff @(negedge MEMCH_READOUT_Clk or negedge MEMCH_STATEMACHINE_Reset) begin
    if (!MEMCH_STATEMACHINE_Reset) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      ch_q             <= '0;
      in_flight_q      <= 1'b0;
      last_in_flight_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      ch_q             <= ch_d;
      in_flight_q      <= in_flight_d;
      last_in_flight_q <= last_in_flight_d;
    end
  end

  // Next state plus address/channel counters; addr and channel saturate, never wrap.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    ch_d             = ch_q;
    in_flight_d      = rd_en;
    last_in_flight_d = rd_en && (addr_q == LAST_ADDR);
    case (state_q)
      ST_IDLE:  if (MEMCH_READOUT_Channel_Done) state_d = ST_FLAG;
      ST_FLAG:  state_d = ST_READ;
      ST_READ: begin
        if (rd_en) begin
          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: if ((buf_count == 2'd0) && !in_flight_q) state_d = ST_WAIT_ADV;
      ST_WAIT_ADV: begin
        if (MEMCH_READOUT_Ch_Advance) begin
          addr_d = '0;
          if (ch_q == LAST_CH) begin
            state_d = ST_DONE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reads are issued only while the words already owed downstream (after this cycle's pop) fit the buffer.
  always_comb begin
    rd_en      = 1'b0;
    new_flag   = 1'b0;
    in_routine = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_FLAG: begin
        new_flag   = 1'b1;
        in_routine = 1'b1;
      end
      ST_READ: begin
        in_routine = 1'b1;
        rd_en      = (occupancy < 3'd2);
      end
      ST_DRAIN: in_routine = 1'b1;
      ST_DONE:  frame_done = 1'b1;
      default:  ;
    endcase
  end

  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid && MEMCH_READOUT_Out_Ready;
  assign occupancy = 3'(buf_count) + 3'(in_flight_q) - 3'(pop);

  memch_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (MEMCH_READOUT_Clk),
    .rst_n    (MEMCH_STATEMACHINE_Reset),
    .push     (in_flight_q),
    .push_data({last_in_flight_q, MEMCH_READOUT_Rd_Data}),
    .pop      (pop),
    .head_data(buf_head),
    .count    (buf_count)
  );

  assign MEMCH_READOUT_Rd_En             = rd_en;
  assign MEMCH_READOUT_Rd_Addr           = addr_q;
  assign MEMCH_READOUT_Rd_Sel            = ch_q;
  assign MEMCH_READOUT_Out_Valid         = out_valid;
  assign MEMCH_READOUT_Out_Data          = out_valid ? buf_head[DATA_WIDTH-1:0] : '0;
  assign MEMCH_READOUT_Out_Last          = out_valid && buf_head[DATA_WIDTH];
  assign MEMCH_READOUT_New_Channel_Flag  = new_flag;
  assign MEMCH_READOUT_In_Output_Routine = in_routine;
  assign MEMCH_READOUT_Frame_Done        = frame_done;

endmodule

// File: tb/tb_memch_readout_sequencer.sv
// Scoreboard bench for the readout sequencer: random memory contents and stream back-pressure,
// plus a second single-pixel, single-channel instance.
module tb_memch_readout_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned P  = 900;
  localparam int unsigned C  = 3;

  logic          clk;
  logic          rst_n;
  logic          ch_done, ch_adv, rd_en, out_valid, out_ready, out_last, flag, routine, frame_done;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_sel;
  logic [DW-1:0] rd_data, out_data;

  logic          rst_s_n, done_s, adv_s, rd_en_s, valid_s, ready_s, last_s, flag_s, routine_s, fdone_s;
  logic [AW-1:0] rd_addr_s;
  logic [0:0]    rd_sel_s;
  logic [DW-1:0] rd_data_s, data_s, m1;

  logic [DW-1:0] mem [C][P];
  logic [8:0]    sb [$];
  int            exp_ch;
  int            issued, accepted;
  int            tests = 0;
  int            fails = 0;

  memch_readout_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIXELS(P), .CHANNELS(C)) u_dut (
    .MEMCH_READOUT_Clk(clk), .MEMCH_STATEMACHINE_Reset(rst_n),
    .MEMCH_READOUT_Channel_Done(ch_done), .MEMCH_READOUT_Ch_Advance(ch_adv),
    .MEMCH_READOUT_Rd_En(rd_en), .MEMCH_READOUT_Rd_Addr(rd_addr), .MEMCH_READOUT_Rd_Sel(rd_sel),
    .MEMCH_READOUT_Rd_Data(rd_data), .MEMCH_READOUT_Out_Data(out_data),
    .MEMCH_READOUT_Out_Valid(out_valid), .MEMCH_READOUT_Out_Ready(out_ready),
    .MEMCH_READOUT_Out_Last(out_last), .MEMCH_READOUT_New_Channel_Flag(flag),
    .MEMCH_READOUT_In_Output_Routine(routine), .MEMCH_READOUT_Frame_Done(frame_done)
  );

  memch_readout_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIXELS(1), .CHANNELS(1)) u_dut_s (
    .MEMCH_READOUT_Clk(clk), .MEMCH_STATEMACHINE_Reset(rst_s_n),
    .MEMCH_READOUT_Channel_Done(done_s), .MEMCH_READOUT_Ch_Advance(adv_s),
    .MEMCH_READOUT_Rd_En(rd_en_s), .MEMCH_READOUT_Rd_Addr(rd_addr_s), .MEMCH_READOUT_Rd_Sel(rd_sel_s),
    .MEMCH_READOUT_Rd_Data(rd_data_s), .MEMCH_READOUT_Out_Data(data_s),
    .MEMCH_READOUT_Out_Valid(valid_s), .MEMCH_READOUT_Out_Ready(ready_s),
    .MEMCH_READOUT_Out_Last(last_s), .MEMCH_READOUT_New_Channel_Flag(flag_s),
    .MEMCH_READOUT_In_Output_Routine(routine_s), .MEMCH_READOUT_Frame_Done(fdone_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Channel memories: data appears one cycle after the read strobe.
  always @(negedge clk) begin
    if (rd_en) begin
      check_eq("rd_sel", int'(rd_sel), exp_ch);
      if (int'(rd_sel) < C && int'(rd_addr) < P) rd_data <= mem[rd_sel][rd_addr];
      else check_eq("rd_range", int'(rd_addr), P - 1);
    end
    if (rd_en_s) begin
      check_eq("s_rd_addr", int'(rd_addr_s), 0);
      rd_data_s <= m1;
    end
  end

  // Reads issued vs words accepted: their difference is everything owed downstream.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued   <= 0;
      accepted <= 0;
    end else begin
      if (rd_en) issued <= issued + 1;
      if (out_valid && out_ready) accepted <= accepted + 1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, bounded occupancy.
  always @(posedge clk) begin
    logic [8:0]    w;
    logic          stall;
    logic [DW-1:0] held_d;
    logic          held_l;
    #1;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check_eq("hold_valid", int'(out_valid), 1);
        check_eq("hold_data", int'(out_data), int'(held_d));
        check_eq("hold_last", int'(out_last), int'(held_l));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("sb_underflow", int'(out_data), -1);
        else begin
          w = sb.pop_front();
          check_eq("data", int'(out_data), int'(w[7:0]));
          check_eq("last", int'(out_last), int'(w[8]));
        end
      end
      check_eq("outstanding_le2", int'(issued - accepted <= 2), 1);
      if ((issued - accepted == 2) && !out_ready) check_eq("rd_en_when_full", int'(rd_en), 0);
      stall  = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_en"}, int'(rd_en), 0);
    check_eq({tag, "_rd_addr"}, int'(rd_addr), 0);
    check_eq({tag, "_rd_sel"}, int'(rd_sel), 0);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_data"}, int'(out_data), 0);
    check_eq({tag, "_out_last"}, int'(out_last), 0);
    check_eq({tag, "_flag"}, int'(flag), 0);
    check_eq({tag, "_routine"}, int'(routine), 0);
    check_eq({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic push_channel();
    for (int i = 0; i < P; i++) sb.push_back({(i == P - 1), mem[exp_ch][i]});
  endtask

  // mode 0: Ready held 1; mode 1: Ready 1,0,0,1 repeating; mode 2: random. noise adds stray inputs.
  task automatic run_channel(input int mode, input bit noise);
    int flag_cnt = 0, flag_cyc = -1, first_v = -1, last_cyc = -1;
    bit done = 0, bad_routine = 0;
    push_channel();
    for (int cyc = 0; cyc < 4 * P + 50 && !done; cyc++) begin
      @(posedge clk);
      if (cyc == 0) ch_done = 1'b1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      ch_adv = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      #1;
      if (flag) begin
        flag_cnt++;
        if (flag_cyc < 0) flag_cyc = cyc;
        if (!noise) ch_done = 1'b0;
      end
      if (out_valid && !routine) bad_routine = 1;
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready && out_last) begin
        last_cyc = cyc;
        done     = 1;
      end
    end
    ch_done = 1'b0;
    ch_adv  = 1'b0;
    check_eq("channel_completed", int'(done), 1);
    check_eq("flag_pulses", flag_cnt, 1);
    check_eq("first_valid_latency", first_v - flag_cyc, 3);
    check_eq("routine_during_stream", int'(bad_routine), 0);
    if (mode == 0) check_eq("full_throughput_span", last_cyc - first_v, P - 1);
  endtask

  task automatic advance(input int hold, input bit expect_done);
    bit bad = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (routine || out_valid || rd_en || frame_done || flag) bad = 1;
    end
    check_eq("wait_adv_quiet", int'(bad), 0);
    @(posedge clk);
    ch_adv = 1'b1;
    @(posedge clk);
    ch_adv = 1'b0;
    if (!expect_done) exp_ch++;
    @(posedge clk);
    #1;
    check_eq("frame_done_after_adv", int'(frame_done), int'(expect_done));
  endtask

  initial begin
    int flag_seen, fd_low, words;
    bit hit;
    rst_n = 1'b0; rst_s_n = 1'b0;
    ch_done = 1'b0; ch_adv = 1'b0; out_ready = 1'b0;
    done_s = 1'b0; adv_s = 1'b0; ready_s = 1'b0;
    rd_data = '0; rd_data_s = '0;
    exp_ch = 0;
    m1 = 8'($urandom);
    for (int c = 0; c < C; c++)
      for (int a = 0; a < P; a++) mem[c][a] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    rst_n = 1'b1;

    run_channel(0, 1'b0);
    advance(20, 1'b0);
    run_channel(1, 1'b1);
    advance(3, 1'b0);
    run_channel(2, 1'b0);
    advance(3, 1'b1);

    // Frame complete: further Channel_Done must not restart anything.
    flag_seen = 0; fd_low = 0;
    ch_done = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (flag || rd_en) flag_seen++;
      if (!frame_done) fd_low++;
    end
    ch_done = 1'b0;
    check_eq("done_ignores_channel_done", flag_seen, 0);
    check_eq("frame_done_held", fd_low, 0);

    // Reset in the middle of a channel, then restart from channel 0, address 0.
    rst_n = 1'b0;
    sb.delete();
    exp_ch = 0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    push_channel();
    hit = 0;
    for (int cyc = 0; cyc < 4 * P && !hit; cyc++) begin
      @(posedge clk);
      if (cyc == 0) ch_done = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (flag) ch_done = 1'b0;
      if (accepted >= 450 && out_valid) hit = 1;
    end
    check_eq("reached_word_450", int'(hit), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    ch_done = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    run_channel(2, 1'b0);
    advance(3, 1'b0);

    // Single-pixel, single-channel instance.
    rst_s_n = 1'b1;
    ready_s = 1'b1;
    words = 0;
    @(posedge clk);
    done_s = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (flag_s) done_s = 1'b0;
      if (valid_s && ready_s) begin
        words++;
        check_eq("s_data", int'(data_s), int'(m1));
        check_eq("s_last", int'(last_s), 1);
      end
    end
    done_s = 1'b0;
    check_eq("s_word_count", words, 1);
    check_eq("s_routine_wait", int'(routine_s), 0);
    check_eq("s_frame_done_before", int'(fdone_s), 0);
    @(posedge clk);
    adv_s = 1'b1;
    @(posedge clk);
    adv_s = 1'b0;
    @(posedge clk);
    #1;
    check_eq("s_frame_done_after", int'(fdone_s), 1);
    check_eq("s_rd_sel", int'(rd_sel_s), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
